// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-port memory with a fixed access latency of WAIT_CYCLES clocks.
// Optional feature: define ARB_FAIRNESS_EN to alternate grants when both
// ports request together; otherwise the data port has strict priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              gnt_mem;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              pick_mem;
  logic              grant;

`ifdef ARB_FAIRNESS_EN
  logic              last_mem;

  // Data port wins unless both request and the previous grant was data.
  always_comb begin
    pick_mem = mem_req & ~(if_req & last_mem);
  end
`else
  // Strict data-port priority.
  always_comb begin
    pick_mem = mem_req;
  end
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and memory-side / ready outputs.
  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || mem_req) begin
          grant    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        ram_en = 1'b1;
        ram_we = lat_we;
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        if_ready  = ~gnt_mem;
        mem_ready = gnt_mem;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign freeze    = (if_req & ~if_ready) | (mem_req & ~mem_ready);

  // Request latching, wait counter and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      gnt_mem   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
`ifdef ARB_FAIRNESS_EN
      last_mem  <= 1'b0;
`endif
    end else begin
      if (grant) begin
        cnt     <= CNT_LOAD;
        gnt_mem <= pick_mem;
`ifdef ARB_FAIRNESS_EN
        last_mem <= pick_mem;
`endif
        if (pick_mem) begin
          lat_we    <= mem_we;
          lat_addr  <= mem_addr;
          lat_wdata <= mem_wdata;
        end else begin
          lat_we    <= 1'b0;
          lat_addr  <= if_addr;
          lat_wdata <= '0;
        end
      end else if (state == BUSY) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!lat_we) begin
          if (gnt_mem) mem_rdata <= ram_rdata;
          else         if_rdata  <= ram_rdata;
        end
      end
    end
  end

endmodule
